// File: rtl/regfile_2r1w.sv
// Parametrised 2-read/1-write register file with registered read ports,
// optional write-to-read bypass and a sequenced clear-all engine.
module regfile_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              clear_req,
    output logic              busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              wr_commit;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    // Read data as it will appear after this edge: includes the same-edge
    // write (bypass) and the same-edge sweep of entry[ptr].
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if ({1'b0, addr} < DEPTH_L) begin
            if (BYPASS != 0 && wr_commit && addr == wr_addr)
                val = wr_data;
            else if (BYPASS != 0 && state == S_CLEAR && addr == ptr)
                val = '0;
            else
                val = mem[addr];
        end
        return val;
    endfunction

    always_comb begin
        wr_commit = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
        a_next    = read_port(rd_a_addr);
        b_next    = read_port(rd_b_addr);
    end

    assign busy = (state == S_CLEAR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            wr_ack    <= 1'b0;
            rd_a_data <= '0;
            rd_b_data <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_ack    <= wr_commit;
            rd_a_data <= a_next;
            rd_b_data <= b_next;
            if (wr_commit) mem[wr_addr] <= wr_data;
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    mem[ptr] <= '0;
                    if (ptr == LAST) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: three configurations (default, no bypass, DEPTH=12)
// driven in parallel and checked every cycle against a behavioural model.
module tb_regfile_2r1w;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_a_addr;
    logic [3:0] rd_b_addr;
    logic       clear_req;

    logic [7:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;
    logic       ack0, ack1, ack2, busy0, busy1, busy2;

    int checks   = 0;
    int failures = 0;

    regfile_2r1w #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .BYPASS(1)) dut0 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(ack0), .rd_a_addr(rd_a_addr), .rd_a_data(rda0), .rd_b_addr(rd_b_addr),
        .rd_b_data(rdb0), .clear_req(clear_req), .busy(busy0));

    regfile_2r1w #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .BYPASS(0)) dut1 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(ack1), .rd_a_addr(rd_a_addr), .rd_a_data(rda1), .rd_b_addr(rd_b_addr),
        .rd_b_data(rdb1), .clear_req(clear_req), .busy(busy1));

    regfile_2r1w #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .BYPASS(1)) dut2 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(ack2), .rd_a_addr(rd_a_addr), .rd_a_data(rda2), .rd_b_addr(rd_b_addr),
        .rd_b_data(rdb2), .clear_req(clear_req), .busy(busy2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: per configuration, memory contents plus the number
    // of sweep cycles still to run and the next entry the sweep zeroes.
    int         m_depth [3] = '{16, 16, 12};
    int         m_byp   [3] = '{1, 0, 1};
    logic [7:0] m_mem   [3][16];
    int         m_left  [3];
    int         m_idx   [3];
    logic [7:0] e_rda   [3];
    logic [7:0] e_rdb   [3];
    logic       e_ack   [3];
    logic       e_busy  [3];

    function automatic logic [7:0] m_read(input int c, input logic [3:0] a, input logic commit);
        if (int'(a) >= m_depth[c]) return 8'h00;
        if (commit && a == wr_addr && m_byp[c] != 0) return wr_data;
        if (m_left[c] > 0 && int'(a) == m_idx[c] && m_byp[c] != 0) return 8'h00;
        return m_mem[c][a];
    endfunction

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_left[c] = 0; m_idx[c] = 0;
            e_rda[c] = '0; e_rdb[c] = '0; e_ack[c] = 1'b0; e_busy[c] = 1'b0;
            for (int i = 0; i < 16; i++) m_mem[c][i] = '0;
        end
        forever begin
            @(posedge clock or posedge reset);
            for (int c = 0; c < 3; c++) begin
                if (reset) begin
                    m_left[c] = 0; m_idx[c] = 0;
                    e_rda[c] = '0; e_rdb[c] = '0; e_ack[c] = 1'b0; e_busy[c] = 1'b0;
                    for (int i = 0; i < 16; i++) m_mem[c][i] = '0;
                end else begin
                    logic commit;
                    commit   = wr_en && m_left[c] == 0 && int'(wr_addr) < m_depth[c];
                    e_rda[c] = m_read(c, rd_a_addr, commit);
                    e_rdb[c] = m_read(c, rd_b_addr, commit);
                    e_ack[c] = commit;
                    if (commit) m_mem[c][wr_addr] = wr_data;
                    if (m_left[c] > 0) begin
                        m_mem[c][m_idx[c]] = 8'h00;
                        m_idx[c]++;
                        m_left[c]--;
                    end else if (clear_req) begin
                        m_left[c] = m_depth[c];
                        m_idx[c]  = 0;
                    end
                    e_busy[c] = (m_left[c] > 0);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_cfg(input int c, input logic [7:0] a, input logic [7:0] b,
                           input logic k, input logic y);
        chk($sformatf("cfg%0d_rd_a_data", c), 32'(a), 32'(e_rda[c]));
        chk($sformatf("cfg%0d_rd_b_data", c), 32'(b), 32'(e_rdb[c]));
        chk($sformatf("cfg%0d_wr_ack", c),    32'(k), 32'(e_ack[c]));
        chk($sformatf("cfg%0d_busy", c),      32'(y), 32'(e_busy[c]));
    endtask

    // Per-cycle comparison against the model, sampled away from the rising edge
    initial begin
        forever begin
            @(negedge clock);
            chk_cfg(0, rda0, rdb0, ack0, busy0);
            chk_cfg(1, rda1, rdb1, ack1, busy1);
            chk_cfg(2, rda2, rdb2, ack2, busy2);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_wr(input logic en, input logic [3:0] a, input logic [7:0] d);
        wr_en = en; wr_addr = a; wr_data = d;
    endtask

    initial begin
        int cnt;
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_a_addr = '0; rd_b_addr = '0; clear_req = 1'b0;
        #1 reset = 1'b1;
        step();
        chk("reset_rd_a", 32'(rda0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h0);
        reset = 1'b0;

        // Reset contents read back as zero
        rd_a_addr = 4'd3; rd_b_addr = 4'd15;
        step();
        chk("t1_rd_a", 32'(rda0), 32'h0);
        chk("t1_rd_b", 32'(rdb0), 32'h0);
        chk("t1_busy", 32'(busy0), 32'h0);

        // Basic write then dual read of the same entry
        set_wr(1'b1, 4'd7, 8'hA5);
        step();
        chk("t2_ack", 32'(ack0), 32'h1);
        set_wr(1'b0, 4'd0, 8'h00);
        rd_a_addr = 4'd7; rd_b_addr = 4'd7;
        step();
        chk("t2_rd_a", 32'(rda0), 32'hA5);
        chk("t2_rd_b", 32'(rdb0), 32'hA5);
        chk("t2_ack_drop", 32'(ack0), 32'h0);

        // Same-edge write/read: bypass vs old value
        set_wr(1'b1, 4'd2, 8'hA5);
        step();
        set_wr(1'b1, 4'd2, 8'h3C);
        rd_a_addr = 4'd2;
        step();
        chk("t3_bypass", 32'(rda0), 32'h3C);
        chk("t3_nobypass", 32'(rda1), 32'hA5);
        set_wr(1'b0, 4'd0, 8'h00);
        step();
        chk("t3_nobypass_after", 32'(rda1), 32'h3C);

        // Fill, then sweep with a write in the clear_req cycle and writes while busy
        for (int i = 0; i < 16; i++) begin
            set_wr(1'b1, 4'(i), 8'(i + 1));
            step();
        end
        set_wr(1'b1, 4'd0, 8'h77);
        clear_req = 1'b1;
        step();
        chk("t4_ack_with_clear", 32'(ack0), 32'h1);
        chk("t4_busy_rise", 32'(busy0), 32'h1);
        cnt = 1;
        for (int i = 1; i < 40; i++) begin
            clear_req = (i == 1);
            set_wr(1'b1, 4'd3, 8'h99);
            rd_a_addr = 4'(i); rd_b_addr = 4'(15 - (i % 16));
            step();
            chk("t4_no_ack_busy", 32'(ack0), 32'h0);
            if (busy0) cnt++;
            else break;
        end
        chk("t4_busy_cycles", 32'(cnt), 32'd16);
        set_wr(1'b0, 4'd0, 8'h00);
        clear_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_a_addr = 4'(i); rd_b_addr = 4'(i);
            step();
            chk("t4_cleared", 32'(rda0), 32'h0);
        end

        // Reset in the middle of a sweep
        for (int i = 0; i < 16; i++) begin
            set_wr(1'b1, 4'(i), 8'(i + 1));
            step();
        end
        set_wr(1'b0, 4'd0, 8'h00);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t5_busy_before", 32'(busy0), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5_busy_async", 32'(busy0), 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_a_addr = 4'(i);
            step();
            chk("t5_zero", 32'(rda0), 32'h0);
        end
        chk("t5_idle", 32'(busy0), 32'h0);
        set_wr(1'b1, 4'd4, 8'h5A);
        rd_a_addr = 4'd0;
        step();
        chk("t5_ack", 32'(ack0), 32'h1);
        set_wr(1'b0, 4'd0, 8'h00);
        rd_a_addr = 4'd4;
        step();
        chk("t5_readback", 32'(rda0), 32'h5A);

        // Out-of-range address on the DEPTH=12 instance
        set_wr(1'b1, 4'd13, 8'hFF);
        step();
        chk("t6_oor_ack", 32'(ack2), 32'h0);
        chk("t6_inrange16_ack", 32'(ack0), 32'h1);
        set_wr(1'b1, 4'd11, 8'h42);
        rd_a_addr = 4'd13;
        step();
        chk("t6_oor_read", 32'(rda2), 32'h0);
        chk("t6_read16", 32'(rda0), 32'hFF);
        chk("t6_last_ack", 32'(ack2), 32'h1);
        set_wr(1'b0, 4'd0, 8'h00);
        rd_a_addr = 4'd11;
        step();
        chk("t6_last_read", 32'(rda2), 32'h42);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
